// File: rtl/mem_dma_if.sv
// mem_dma_if: control and memory-port signals of the block copy/fill engine
interface mem_dma_if #(parameter int AW = 16, parameter int DW = 16, parameter int LW = 16);
  logic start;
  logic mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] fill_val;
  logic busy;
  logic done;
  logic [LW-1:0] remaining;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_wr;
  logic [DW-1:0] mem_rdata;
  modport master (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    input busy, done, remaining, mem_addr, mem_wdata, mem_wr
  );
  modport slave (
    input start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    output busy, done, remaining, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_dma_initiator.sv
// mem_dma_initiator: block copy/fill engine issuing one single-port memory access per cycle
module mem_dma_initiator #(parameter int AW = 16, parameter int DW = 16, parameter int LW = 16) (
  input logic clk,
  input logic rst,
  mem_dma_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic r_mode;
  logic [AW-1:0] r_src, r_dst;
  logic [LW-1:0] r_rem;
  logic [DW-1:0] r_fill, r_rbuf;
  logic w_read, w_write;
  assign w_read  = r_state == READ;
  assign w_write = r_state == WRITE;
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE  ? (bus.start ? (bus.len == '0 ? DONE : bus.mode ? WRITE : READ) : IDLE) :
             r_state == READ  ? WRITE :
             r_state == WRITE ? (r_rem == LW'(1) ? DONE : r_mode ? WRITE : READ) :
             IDLE;
  end
  assign bus.busy      = w_read | w_write;
  assign bus.done      = r_state == DONE;
  assign bus.mem_wr    = w_write;
  assign bus.mem_addr  = w_read ? r_src : w_write ? r_dst : '0;
  assign bus.mem_wdata = w_write ? (r_mode ? r_fill : r_rbuf) : '0;
  assign bus.remaining = r_rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_fill  <= '0;
      r_rbuf  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_mode <= bus.mode;
        r_src  <= bus.src_addr;
        r_dst  <= bus.dst_addr;
        r_rem  <= bus.len;
        r_fill <= bus.fill_val;
      end
      if (w_read) r_rbuf <= bus.mem_rdata;
      if (w_write) begin
        r_dst <= r_dst + AW'(1);
        if (!r_mode) r_src <= r_src + AW'(1);
        r_rem <= r_rem - LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_dma_initiator.sv
// tb_mem_dma_initiator: random and directed copy/fill transfers against a word-level memory model
module tb_mem_dma_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  mem_dma_if #(.AW(16), .DW(16), .LW(16)) bus ();
  mem_dma_initiator #(.AW(16), .DW(16), .LW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_wr"}, 32'(bus.mem_wr), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_rem"}, 32'(bus.remaining), 0);
  endtask
  task automatic mem_chk(input string tag);
    int bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk(tag, bad, 0);
  endtask
  // transfer: poke_c issues a stray start with dst 0x0200 in that cycle, rst_c asserts reset in that cycle
  task automatic run(input logic m, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                     input logic [15:0] f, input int poke_c, input int rst_c);
    int li, dc, nw, last, k;
    logic eb, ew;
    logic [15:0] ea;
    li = int'(l);
    dc = li == 0 ? 1 : m ? li + 1 : 2 * li + 1;
    nw = rst_c == 0 ? li : m ? (rst_c < li ? rst_c : li) : (rst_c / 2 < li ? rst_c / 2 : li);
    for (int i = 0; i < nw; i++) ref_mem[d + 16'(i)] = m ? f : ref_mem[s + 16'(i)];
    last = rst_c != 0 ? rst_c : dc;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d; bus.len = l; bus.fill_val = f;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mode = 1'($urandom); bus.src_addr = 16'($urandom);
    bus.dst_addr = 16'($urandom); bus.len = 16'($urandom); bus.fill_val = 16'($urandom);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (rst_c != 0 && c == rst_c + 1) begin
        idle_chk("rst_mid");
        rst = 1'b0;
      end else begin
        eb = li != 0 && (m ? c <= li : c <= 2 * li);
        ew = eb && (m || c % 2 == 0);
        k  = m ? c - 1 : (c - 1) / 2;
        ea = !eb ? 16'h0 : (!m && c % 2 == 1) ? s + 16'(k) : d + 16'(k);
        chk("busy", 32'(bus.busy), 32'(eb));
        chk("done", 32'(bus.done), 32'(c == dc));
        chk("wr", 32'(bus.mem_wr), 32'(ew));
        chk("addr", 32'(bus.mem_addr), 32'(ea));
        chk("rem", 32'(bus.remaining), eb ? 32'(li - k) : 0);
        if (!ew) chk("wdata_idle", 32'(bus.mem_wdata), 0);
      end
      bus.start = c == poke_c;
      if (c == poke_c) bus.dst_addr = 16'h0200;
      if (rst_c != 0 && c == rst_c) rst = 1'b1;
    end
    bus.start = 1'b0;
    mem_chk("mem");
  endtask
  initial begin
    logic [15:0] v, s, d;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0; bus.fill_val = '0;
    for (int a = 0; a < 65536; a++) begin
      v = 16'($urandom);
      mem[a] <= v;
      ref_mem[a] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    poke(16'h0010, 16'h1111); poke(16'h0011, 16'h2222); poke(16'h0012, 16'h3333); poke(16'h0013, 16'h4444);
    run(1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0, 0, 0);
    chk("copy_w0", 32'(mem[16'h0100]), 32'h1111);
    chk("copy_w3", 32'(mem[16'h0103]), 32'h4444);
    v = mem[16'h0004];
    run(1'b1, 16'h0, 16'hFFFC, 16'd8, 16'hA5A5, 0, 0);
    chk("fill_ffff", 32'(mem[16'hFFFF]), 32'hA5A5);
    chk("fill_0003", 32'(mem[16'h0003]), 32'hA5A5);
    chk("fill_0004", 32'(mem[16'h0004]), 32'(v));
    run(1'b0, 16'h1234, 16'h5678, 16'd0, 16'h0, 0, 0);
    poke(16'h0200, 16'h5A5A);
    run(1'b0, 16'h0010, 16'h0300, 16'd4, 16'h0, 3, 0);
    chk("stray_0200", 32'(mem[16'h0200]), 32'h5A5A);
    poke(16'h0020, 16'h00AB);
    run(1'b0, 16'h0020, 16'h0021, 16'd3, 16'h0, 0, 0);
    chk("overlap_23", 32'(mem[16'h0023]), 32'h00AB);
    run(1'b0, 16'h0010, 16'h0400, 16'd4, 16'h0, 0, 5);
    run(1'b0, 16'h0010, 16'h0500, 16'd4, 16'h0, 0, 0);
    for (int t = 0; t < 12; t++) begin
      s = 16'($urandom);
      d = $urandom_range(0, 1) != 0 ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
      run(1'($urandom), s, d, 16'($urandom_range(0, 12)), 16'($urandom), 0, 0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_dma_initiator.md
Name: mem_dma_initiator

Overview:
Memory-side initiator that drives the addr/idata/wr/odata port of the 64K x 16 single-port data memory. It performs block copy (src -> dst) or block fill (constant -> dst) on a single start pulse, so the accelerator control logic does not sequence word-by-word accesses. The memory read is combinational (same-cycle odata) and its write is synchronous on posedge clk. The engine issues exactly one memory access per cycle.

Parameters:
AW, 16, address width; addresses wrap modulo 2^AW
DW, 16, data word width
LW, 16, transfer length width (words)

Ports:
clk        input   1    system clock, posedge
rst        input   1    synchronous active-high reset
start      input   1    begin transfer; sampled only in IDLE
mode       input   1    0 = copy, 1 = fill
src_addr   input   AW   copy source base address (ignored in fill mode)
dst_addr   input   AW   destination base address
len        input   LW   number of words to transfer
fill_val   input   DW   fill constant (ignored in copy mode)
busy       output  1    high in READ/WRITE states
done       output  1    one-cycle completion pulse
remaining  output  LW   words not yet written
mem_addr   output  AW   to memory addr
mem_wdata  output  DW   to memory idata
mem_wr     output  1    to memory wr
mem_rdata  input   DW   from memory odata (combinational read)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. busy, done, mem_wr, mem_addr, mem_wdata and remaining are all 0. All internal pointers and buffers are 0. Reset has priority over every other input.
- States are IDLE, READ, WRITE and DONE. Memory outputs are decoded from state and registers.
- IDLE: mem_wr=0, mem_addr=0, mem_wdata=0. On start=1, latch mode, src_addr, dst_addr, len and fill_val into internal cur_src, cur_dst, remaining and buffers.
  - If len=0: go to DONE.
  - Else if mode=0: go to READ.
  - Else: go to WRITE.
- READ (copy only): mem_addr=cur_src, mem_wr=0. At posedge, capture mem_rdata into rbuf and go to WRITE.
- WRITE: mem_addr=cur_dst, mem_wr=1. mem_wdata=rbuf in copy mode, fill_val_latched in fill mode. At posedge:
  - cur_dst+=1 and, in copy mode, cur_src+=1, both mod 2^AW.
  - remaining-=1.
  - If remaining was 1: go to DONE.
  - Else copy mode goes to READ; fill mode stays in WRITE.
- DONE: done=1 for exactly one cycle, busy=0, mem_wr=0. Then go to IDLE unconditionally. start in DONE is ignored.
- Latency, counted in cycles after the start edge:
  - Copy takes 2*len cycles of access; done is high in cycle 2*len+1.
  - Fill takes len cycles; done is high in cycle len+1.
  - len=0: done is high in cycle 1 and no write is issued.
- start while busy or in DONE is ignored; the latched parameters are not disturbed.
- Input ports may change after the start edge without effect.
- Address wrap: 0xFFFF+1 -> 0x0000 for both pointers; no error is raised.
- Overlapping copy: strictly forward, word by word. Each READ observes all earlier WRITEs of the same transfer (memory semantics are defined, not undefined).
- Reset mid-transfer: the next cycle is IDLE with mem_wr=0. Writes already performed remain; no further writes occur and no done pulse is generated.
- len is an unsigned count; the maximum is 2^LW-1 words.

Test Plan:
- Copy: preload mem[0x0010..0x0013]=1111,2222,3333,4444; start mode=0 src=0x0010 dst=0x0100 len=4 -> mem[0x0100..0x0103] hold the same values. mem_wr is high on cycles 2,4,6,8. done is high only on cycle 9. busy is high on cycles 1-8.
- Fill with wrap: start mode=1 dst=0xFFFC len=8 fill_val=0xA5A5 -> mem[0xFFFC..0xFFFF] and mem[0x0000..0x0003]=0xA5A5. done is on cycle 9. mem[0x0004] is unchanged.
- Zero length: start len=0 -> done is high on cycle 1, mem_wr never asserts, busy stays 0.
- Ignored start: second start with dst=0x0200 issued on cycle 3 of a len=4 copy -> no write to 0x0200, and the original transfer completes unchanged on cycle 9.
- Overlap: mem[0x0020]=0x00AB; copy src=0x0020 dst=0x0021 len=3 -> mem[0x0021..0x0023]=0x00AB.
- Reset mid-copy: rst=1 on cycle 5 of a len=4 copy -> exactly 2 destination words written, then IDLE. All outputs are 0 and no done pulse occurs. A new start afterwards works normally.
